// File: rtl/llc_rst_flush_seq_if.sv
// llc_rst_flush_seq_if: control/handshake bundle between the LLC reset/flush
// sequencer (master) and the tag array, stall registers and set counter (slave).
interface llc_rst_flush_seq_if #(
    parameter int N_SETS = 1024,
    parameter int N_WAYS = 16
);
    localparam int SB = $clog2(N_SETS);
    localparam int WB = $clog2(N_WAYS);

    logic                  rst_state;
    logic                  flush_req;
    logic [SB-1:0]         cur_set;
    logic                  clr_rst_flush_stalled_set;
    logic                  incr_rst_flush_stalled_set;
    logic                  update_en;
    logic                  clr_rst_stall;
    logic                  set_flush_stall;
    logic                  clr_flush_stall;
    logic                  tag_wr_valid;
    logic                  tag_wr_ready;
    logic                  rd_set_valid;
    logic                  rd_set_ready;
    logic [2*N_WAYS-1:0]   states_in;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [SB-1:0]         wb_set;
    logic [WB-1:0]         wb_way;
    logic                  busy;

    modport master (
        input  rst_state, flush_req, cur_set, tag_wr_ready, rd_set_ready,
               states_in, wb_ready,
        output clr_rst_flush_stalled_set, incr_rst_flush_stalled_set, update_en,
               clr_rst_stall, set_flush_stall, clr_flush_stall,
               tag_wr_valid, rd_set_valid, wb_valid, wb_set, wb_way, busy
    );

    modport slave (
        output rst_state, flush_req, cur_set, tag_wr_ready, rd_set_ready,
               states_in, wb_ready,
        input  clr_rst_flush_stalled_set, incr_rst_flush_stalled_set, update_en,
               clr_rst_stall, set_flush_stall, clr_flush_stall,
               tag_wr_valid, rd_set_valid, wb_valid, wb_set, wb_way, busy
    );
endinterface

// File: rtl/llc_rst_flush_seq.sv
// llc_rst_flush_seq: LLC tag reset sweep and dirty-line flush sequencer.
// The flush path (FL_* states) is built only when LLC_FLUSH_EN is defined.
module llc_rst_flush_seq #(
    parameter int N_SETS = 1024,
    parameter int N_WAYS = 16
) (
    input  logic                clk,
    input  logic                rst,
    llc_rst_flush_seq_if.master bus
);
    localparam int SB = $clog2(N_SETS);
    localparam int WB = $clog2(N_WAYS);
    localparam logic [SB-1:0] LAST_SET = SB'(N_SETS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_WR  = 3'd1,
        FL_RD   = 3'd2,
        FL_CAP  = 3'd3,
        FL_SCAN = 3'd4,
        FL_WB   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          last_set;
    logic          clr_cnt, incr, clr_rst_stall, set_fstall, clr_fstall;
    logic          tag_wr_valid, rd_set_valid, wb_valid;
    logic [SB-1:0] wb_set;
    logic [WB-1:0] wb_way;

    assign last_set = (bus.cur_set == LAST_SET);

`ifdef LLC_FLUSH_EN
    logic [N_WAYS-1:0] mask_q, mask_d, dirty_pend;
    logic [WB-1:0]     way_q, way_d, low_way;

    for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_pend
        assign dirty_pend[gi] = bus.states_in[2*gi] & bus.states_in[2*gi+1];
    end

    // Lowest pending way wins, so writebacks within a set go in ascending order.
    always_comb begin
        low_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (mask_q[w]) low_way = WB'(w);
        end
    end

    always_comb begin
        mask_d = mask_q;
        way_d  = way_q;
        if (bus.rst_state) begin
            mask_d = '0;
        end else begin
            case (state_q)
                FL_CAP:  mask_d = dirty_pend;
                FL_SCAN: way_d  = low_way;
                FL_WB:   if (bus.wb_ready) mask_d[way_q] = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= '0;
            way_q  <= '0;
        end else begin
            mask_q <= mask_d;
            way_q  <= way_d;
        end
    end
`else
    logic unused_flush_inputs;
    assign unused_flush_inputs = ^{bus.flush_req, bus.rd_set_ready, bus.states_in, bus.wb_ready};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.rst_state) begin
            state_d = RST_WR;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef LLC_FLUSH_EN
                    if (bus.flush_req) state_d = FL_RD;
`endif
                end
                RST_WR:  if (bus.tag_wr_ready && last_set) state_d = IDLE;
`ifdef LLC_FLUSH_EN
                FL_RD:   if (bus.rd_set_ready) state_d = FL_CAP;
                FL_CAP:  state_d = FL_SCAN;
                FL_SCAN: begin
                    if (mask_q != '0)  state_d = FL_WB;
                    else if (last_set) state_d = IDLE;
                    else               state_d = FL_RD;
                end
                FL_WB:   if (bus.wb_ready) state_d = FL_SCAN;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter controls are Mealy so the external counter advances on the same
    // edge as the handshake and cur_set is already correct for the next request.
    always_comb begin
        clr_cnt       = 1'b0;
        incr          = 1'b0;
        clr_rst_stall = 1'b0;
        set_fstall    = 1'b0;
        clr_fstall    = 1'b0;
        tag_wr_valid  = 1'b0;
        rd_set_valid  = 1'b0;
        wb_valid      = 1'b0;
        wb_set        = '0;
        wb_way        = '0;
        if (!rst) begin
            clr_cnt = 1'b0;
        end else if (bus.rst_state) begin
            clr_cnt = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef LLC_FLUSH_EN
                    if (bus.flush_req) begin
                        set_fstall = 1'b1;
                        clr_cnt    = 1'b1;
                    end
`endif
                end
                RST_WR: begin
                    tag_wr_valid = 1'b1;
                    if (bus.tag_wr_ready) begin
                        if (last_set) begin
                            clr_rst_stall = 1'b1;
                            clr_cnt       = 1'b1;
                        end else begin
                            incr = 1'b1;
                        end
                    end
                end
`ifdef LLC_FLUSH_EN
                FL_RD: rd_set_valid = 1'b1;
                FL_SCAN: begin
                    if (mask_q == '0) begin
                        if (last_set) begin
                            clr_fstall = 1'b1;
                            clr_cnt    = 1'b1;
                        end else begin
                            incr = 1'b1;
                        end
                    end
                end
                FL_WB: begin
                    wb_valid = 1'b1;
                    wb_set   = bus.cur_set;
                    wb_way   = way_q;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.clr_rst_flush_stalled_set  = clr_cnt;
    assign bus.incr_rst_flush_stalled_set = incr;
    assign bus.update_en                  = incr;
    assign bus.clr_rst_stall              = clr_rst_stall;
    assign bus.set_flush_stall            = set_fstall;
    assign bus.clr_flush_stall            = clr_fstall;
    assign bus.tag_wr_valid               = tag_wr_valid;
    assign bus.rd_set_valid               = rd_set_valid;
    assign bus.wb_valid                   = wb_valid;
    assign bus.wb_set                     = wb_set;
    assign bus.wb_way                     = wb_way;
    assign bus.busy                       = (state_q != IDLE);
endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// tb_llc_rst_flush_seq: directed and randomized checks of the LLC reset/flush
// sequencer against a set-list/writeback-list reference model.
module tb_llc_rst_flush_seq;
    localparam int N_SETS = 4;
    localparam int N_WAYS = 4;
    localparam int SB = $clog2(N_SETS);
    localparam int WB = $clog2(N_WAYS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    llc_rst_flush_seq_if #(.N_SETS(N_SETS), .N_WAYS(N_WAYS)) bus ();
    llc_rst_flush_seq #(.N_SETS(N_SETS), .N_WAYS(N_WAYS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int cnt = 0;
    logic [2*N_WAYS-1:0] states_mem [N_SETS];
    int  stall_set = -1;
    int  stall_left = 0;
    bit  rnd_rdy = 1'b0;
    bit  wb_hold = 1'b0;

    int tag_q[$], rd_q[$], wb_q[$], exp_q[$];
    int n_incr, n_clr_cnt, n_crs, n_sfs, n_cfs, n_stall, n_rdv, n_wbv, n_busy, n_viol;
    int rst_cyc, crs_cyc;
    bit prev_wb_wait;
    logic [SB+WB-1:0] prev_wb;
    logic s_busy, s_tag_valid, s_wb_valid;
    int   s_wb_set, s_cur_set;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int obs[$], input int exp[$]);
        chk({tag, "_len"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < obs.size()) ? obs[i] : -1, exp[i]);
    endtask

    task automatic clear_log();
        tag_q.delete(); rd_q.delete(); wb_q.delete();
        n_incr = 0; n_clr_cnt = 0; n_crs = 0; n_sfs = 0; n_cfs = 0;
        n_stall = 0; n_rdv = 0; n_wbv = 0; n_busy = 0; n_viol = 0;
        rst_cyc = -100; crs_cyc = -1; prev_wb_wait = 1'b0;
    endtask

    // Reference: a full sweep visits every set once, in ascending order.
    task automatic model_sets();
        exp_q.delete();
        for (int s = 0; s < N_SETS; s++) exp_q.push_back(s);
    endtask

    // Reference: every valid+dirty way, by ascending set then ascending way.
    task automatic model_wb();
        exp_q.delete();
        for (int s = 0; s < N_SETS; s++)
            for (int w = 0; w < N_WAYS; w++)
                if (states_mem[s][2*w] && states_mem[s][2*w+1]) exp_q.push_back(s*N_WAYS + w);
    endtask

    // One clock: sample/log at negedge, then advance the external counter and
    // drive next-cycle inputs just after the rising edge.
    task automatic cycle();
        bit hs_rd, clr, inc;
        int rd_set;
        @(negedge clk);
        if (bus.rst_state) rst_cyc = ncyc;
        if (bus.tag_wr_valid && bus.tag_wr_ready) tag_q.push_back(int'(bus.cur_set));
        if (bus.tag_wr_valid && !bus.tag_wr_ready) begin
            n_stall++;
            if (stall_left > 0 && cnt == stall_set) stall_left--;
        end
        hs_rd  = bus.rd_set_valid && bus.rd_set_ready;
        rd_set = int'(bus.cur_set);
        if (hs_rd) rd_q.push_back(rd_set);
        if (bus.rd_set_valid) n_rdv++;
        if (bus.wb_valid) n_wbv++;
        if (bus.busy) n_busy++;
        if (bus.wb_valid && bus.wb_ready) wb_q.push_back(int'(bus.wb_set)*N_WAYS + int'(bus.wb_way));
        if (bus.incr_rst_flush_stalled_set) n_incr++;
        if (bus.clr_rst_stall) begin n_crs++; crs_cyc = ncyc; end
        if (bus.set_flush_stall) n_sfs++;
        if (bus.clr_flush_stall) n_cfs++;
        if (bus.clr_rst_flush_stalled_set) n_clr_cnt++;
        if (bus.incr_rst_flush_stalled_set != bus.update_en) n_viol++;
        if (bus.incr_rst_flush_stalled_set && bus.tag_wr_valid && !bus.tag_wr_ready) n_viol++;
        if (int'(bus.tag_wr_valid) + int'(bus.rd_set_valid) + int'(bus.wb_valid) > 1) n_viol++;
        if ((bus.tag_wr_valid || bus.rd_set_valid || bus.wb_valid) && !bus.busy) n_viol++;
        if (prev_wb_wait && rst && !bus.rst_state &&
            (!bus.wb_valid || {bus.wb_set, bus.wb_way} != prev_wb)) n_viol++;
        prev_wb_wait = bus.wb_valid && !bus.wb_ready;
        prev_wb      = {bus.wb_set, bus.wb_way};
        s_busy      = bus.busy;
        s_tag_valid = bus.tag_wr_valid;
        s_wb_valid  = bus.wb_valid;
        s_wb_set    = int'(bus.wb_set);
        s_cur_set   = int'(bus.cur_set);
        clr = bus.clr_rst_flush_stalled_set;
        inc = bus.incr_rst_flush_stalled_set && bus.update_en;
        @(posedge clk);
        #1;
        ncyc++;
        if (clr) cnt = 0;
        else if (inc) cnt = (cnt + 1) % N_SETS;
        bus.cur_set   = SB'(cnt);
        bus.states_in = hs_rd ? states_mem[rd_set] : (2*N_WAYS)'($urandom);
        bus.rst_state = 1'b0;
        bus.flush_req = 1'b0;
        bus.tag_wr_ready = (stall_left > 0 && cnt == stall_set) ? 1'b0 :
                           (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        bus.rd_set_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.wb_ready     = wb_hold ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (s_busy && n < budget);
        chk({tag, "_idle"}, int'(s_busy), 0);
    endtask

    task automatic check_sweep(input string tag, input int extra_stall);
        model_sets();
        chk_q({tag, "_sets"}, tag_q, exp_q);
        chk({tag, "_incr"}, n_incr, N_SETS - 1);
        chk({tag, "_clr_rst_stall"}, n_crs, 1);
        chk({tag, "_span"}, crs_cyc - rst_cyc + 1, N_SETS + 1 + extra_stall);
        chk({tag, "_viol"}, n_viol, 0);
    endtask

    initial begin
        rst = 1'b0;
        bus.rst_state = 1'b0; bus.flush_req = 1'b0; bus.cur_set = '0;
        bus.tag_wr_ready = 1'b1; bus.rd_set_ready = 1'b1; bus.wb_ready = 1'b1;
        bus.states_in = '0;
        for (int s = 0; s < N_SETS; s++) states_mem[s] = '0;
        clear_log();

        // Held in reset with requests asserted: nothing may move.
        for (int i = 0; i < 3; i++) begin
            bus.rst_state = 1'b1; bus.flush_req = 1'b1;
            cycle();
        end
        chk("rst_busy", n_busy, 0);
        chk("rst_clr_cnt", n_clr_cnt, 0);
        chk("rst_set_fstall", n_sfs, 0);
        rst = 1'b1;
        clear_log();
        repeat (2) cycle();
        chk("post_rst_busy", n_busy, 0);
        chk("post_rst_tag_valid", int'(s_tag_valid), 0);

        // Basic reset sweep, always ready.
        clear_log();
        bus.rst_state = 1'b1; cycle();
        wait_idle("sweep", 50);
        check_sweep("sweep", 0);
        chk("sweep_cnt_clr", n_clr_cnt, 2);
        chk("sweep_cnt_end", cnt, 0);

        // Backpressure: three not-ready cycles on set 2.
        clear_log();
        stall_set = 2; stall_left = 3;
        bus.rst_state = 1'b1; cycle();
        wait_idle("bp", 50);
        check_sweep("bp", 3);
        chk("bp_stall", n_stall, 3);
        stall_set = -1;

        // Random readiness, sweep restarted at a random point.
        rnd_rdy = 1'b1;
        for (int it = 0; it < 4; it++) begin
            bus.rst_state = 1'b1; cycle();
            repeat ($urandom_range(0, 5)) cycle();
            clear_log();
            bus.rst_state = 1'b1; cycle();
            wait_idle($sformatf("rnd%0d", it), 200);
            check_sweep($sformatf("rnd%0d", it), n_stall);
        end
        rnd_rdy = 1'b0;
        repeat (2) cycle();

        // Reset asserted mid-sweep abandons it.
        clear_log();
        bus.rst_state = 1'b1; cycle();
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        chk("midrst_busy", int'(s_busy), 0);
        chk("midrst_tag_valid", int'(s_tag_valid), 0);
        rst = 1'b1;
        repeat (4) cycle();
        chk("midrst_stays_idle", int'(s_busy), 0);
        chk("midrst_hs", tag_q.size(), 2);
        chk("midrst_no_clr_rst_stall", n_crs, 0);

        // Simultaneous rst_state+flush_req, then flush_req during RST_WR.
        clear_log();
        bus.rst_state = 1'b1; bus.flush_req = 1'b1; cycle();
        bus.flush_req = 1'b1; cycle();
        wait_idle("simul", 50);
        model_sets();
        chk_q("simul_sets", tag_q, exp_q);
        chk("simul_set_fstall", n_sfs, 0);
        chk("simul_rd_valid", n_rdv, 0);
        chk("simul_viol", n_viol, 0);

`ifdef LLC_FLUSH_EN
        // Directed flush: set 1 has ways 0 and 2 dirty, way 3 clean.
        states_mem[1] = 8'h73;
        clear_log();
        bus.flush_req = 1'b1; cycle();
        wait_idle("fl", 100);
        model_wb();
        chk_q("fl_wb", wb_q, exp_q);
        model_sets();
        chk_q("fl_rd", rd_q, exp_q);
        chk("fl_set_fstall", n_sfs, 1);
        chk("fl_clr_fstall", n_cfs, 1);
        chk("fl_incr", n_incr, N_SETS - 1);
        chk("fl_viol", n_viol, 0);

        // Randomized flushes.
        rnd_rdy = 1'b1;
        for (int it = 0; it < 4; it++) begin
            for (int s = 0; s < N_SETS; s++) states_mem[s] = (2*N_WAYS)'($urandom);
            clear_log();
            bus.flush_req = 1'b1; cycle();
            wait_idle($sformatf("rfl%0d", it), 400);
            model_wb();
            chk_q($sformatf("rfl%0d_wb", it), wb_q, exp_q);
            chk($sformatf("rfl%0d_clr_fstall", it), n_cfs, 1);
            chk($sformatf("rfl%0d_viol", it), n_viol, 0);
        end
        rnd_rdy = 1'b0;

        // Reset sweep preempts a stalled writeback on set 2.
        for (int s = 0; s < N_SETS; s++) states_mem[s] = '0;
        states_mem[2] = 8'h0C;
        wb_hold = 1'b1;
        clear_log();
        bus.flush_req = 1'b1; cycle();
        begin
            int n = 0;
            do begin cycle(); n++; end while (!(s_wb_valid && s_wb_set == 2) && n < 100);
        end
        chk("pre_wb_reached", int'(s_wb_valid && s_wb_set == 2), 1);
        wb_hold = 1'b0;
        bus.rst_state = 1'b1; cycle();
        cycle();
        chk("pre_wb_dropped", int'(s_wb_valid), 0);
        chk("pre_cnt_cleared", s_cur_set, 0);
        chk("pre_tag_valid", int'(s_tag_valid), 1);
        tag_q.delete();
        tag_q.push_back(0);
        n_crs = 0;
        wait_idle("pre", 50);
        model_sets();
        chk_q("pre_sets", tag_q, exp_q);
        chk("pre_clr_rst_stall", n_crs, 1);
        chk("pre_no_clr_fstall", n_cfs, 0);
        chk("pre_no_wb", wb_q.size(), 0);
`else
        // Flush path compiled out: flush_req must be ignored.
        clear_log();
        bus.flush_req = 1'b1; cycle();
        repeat (4) cycle();
        chk("nofl_busy", n_busy, 0);
        chk("nofl_set_fstall", n_sfs, 0);
        chk("nofl_clr_fstall", n_cfs, 0);
        chk("nofl_rd_valid", n_rdv, 0);
        chk("nofl_wb_valid", n_wbv, 0);
        chk("nofl_clr_cnt", n_clr_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/llc_rst_flush_seq.md
LLC_RST_FLUSH_SEQ -- requirements
Module: llc_rst_flush_seq

Interface
REQ-001 SHALL have parameter N_SETS, default 1024, number of LLC sets (power of 2, at least 2); SB = log2(N_SETS).
REQ-002 SHALL have parameter N_WAYS, default 16, number of ways per set (power of 2, at least 2); WB = log2(N_WAYS).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rst_state  in  1  pulse that starts a reset sweep.
REQ-006 SHALL have port flush_req  in  1  pulse that starts a flush sweep.
REQ-007 SHALL have port cur_set  in  SB  current value of the external rst_flush_stalled_set counter.
REQ-008 SHALL have ports clr_rst_flush_stalled_set, incr_rst_flush_stalled_set and update_en  out  1 each  counter control; incr is always issued together with update_en.
REQ-009 SHALL have ports clr_rst_stall, set_flush_stall and clr_flush_stall  out  1 each  single-cycle pulses to the stall registers.
REQ-010 SHALL have ports tag_wr_valid  out  1 and tag_wr_ready  in  1  request to write all ways of cur_set to invalid.
REQ-011 SHALL have ports rd_set_valid  out  1 and rd_set_ready  in  1  request to read the way states of cur_set.
REQ-012 SHALL have port states_in  in  2*N_WAYS  per way {dirty, valid}, valid one cycle after the rd_set handshake.
REQ-013 SHALL have ports wb_valid  out  1, wb_ready  in  1, wb_set  out  SB and wb_way  out  WB  writeback request.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, RST_WR, FL_RD, FL_CAP, FL_SCAN and FL_WB.
REQ-016 SHALL, on rst_state in any state, pulse clr_rst_flush_stalled_set, drop any outstanding request, and enter RST_WR on the next cycle.
REQ-017 SHALL, in RST_WR, hold tag_wr_valid high; on each handshake, pulse incr+update_en if cur_set is not N_SETS-1, else pulse clr_rst_stall and clr_rst_flush_stalled_set and go to IDLE.
REQ-018 SHALL, on flush_req in IDLE with rst_state low, pulse set_flush_stall and clr_rst_flush_stalled_set and enter FL_RD.
REQ-019 SHALL ignore flush_req when not in IDLE; if rst_state and flush_req arrive in the same cycle, the reset sweep wins.
REQ-020 SHALL, in FL_RD, hold rd_set_valid high until handshake, then enter FL_CAP.
REQ-021 SHALL, in FL_CAP, latch a dirty-pending mask (bit w = valid_w AND dirty_w) from states_in and enter FL_SCAN.
REQ-022 SHALL, in FL_SCAN, go to FL_WB if the mask is non-zero, with wb_way set to the lowest set bit and wb_set set to cur_set.
REQ-023 SHALL, in FL_SCAN with an empty mask: if cur_set is N_SETS-1, pulse clr_flush_stall and clr_rst_flush_stalled_set and go to IDLE; otherwise pulse incr+update_en and go to FL_RD.
REQ-024 SHALL, in FL_WB, hold wb_valid, wb_set and wb_way stable until wb_ready; on handshake, clear that mask bit and return to FL_SCAN.
REQ-025 SHALL keep every pulse output exactly one cycle wide and keep valid outputs low outside their owning state.
REQ-026 SHALL take exactly N_SETS tag_wr handshakes per reset sweep, with a minimum of N_SETS+1 cycles from rst_state to clr_rst_stall.

Reset
REQ-027 SHALL, while rst is low, force the state to IDLE, clear the mask, drive all outputs to 0, and stay that way regardless of clk.
REQ-028 SHALL, when rst is deasserted mid-sweep, leave the sweep abandoned; resuming it requires a new rst_state.

Configuration
REQ-029 SHALL, with macro LLC_FLUSH_EN defined, implement the flush path (FL_* states) as specified.
REQ-030 SHALL, without LLC_FLUSH_EN, compile out the flush path: flush_req is ignored, and rd_set_valid, wb_valid, set_flush_stall and clr_flush_stall are tied to 0.

Verification
REQ-031 SHALL cover the reset sweep: N_SETS=4, tag_wr_ready=1, pulse rst_state -> 4 tag_wr handshakes, 3 incr pulses, clr_rst_stall 5 cycles after rst_state, then busy=0.
REQ-032 SHALL cover reset backpressure: tag_wr_ready low for 3 cycles on set 2 -> tag_wr_valid held, no incr until handshake, total 8 cycles.
REQ-033 SHALL cover flush writebacks: N_WAYS=4, set 1 states {dirty,valid}=way0 11, way2 11, way3 01 -> wb_way 0 then 2 at wb_set 1, no writeback for way 3, and clr_flush_stall after set 3.
REQ-034 SHALL cover reset priority: rst_state during FL_WB on set 2 -> wb_valid drops next cycle, counter cleared, reset sweep completes over 4 sets.
REQ-035 SHALL cover simultaneous requests: rst_state and flush_req in the same cycle -> set_flush_stall never pulses; flush_req during RST_WR -> ignored.
REQ-036 SHALL cover the compile-out case: without LLC_FLUSH_EN, flush_req pulse -> busy stays 0 and all flush outputs stay 0.
